// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding and default baud constants.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_tx_state_t;

    localparam int UART_CLK_HZ = 50_000_000;
    localparam int UART_BAUD   = 115_200;

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and pulses bit_done on the last
// cycle of each period. Held at zero while clr is high so a frame always starts
// on a fresh period boundary.
module uart_baud_gen #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic bit_done
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt;

    // Free-running period counter, wrapped at the period end and cleared on demand.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr || cnt == CNT_MAX) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign bit_done = !clr && (cnt == CNT_MAX);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter that pops one FIFO word per frame and shifts it out
// LSB-first with optional even parity and one or two stop bits.
// Handshake: fifo_rd is a combinational pop strobe, high only in IDLE when
// tx_en=1 and fifo_empty=0; the head word on fifo_rd_data is consumed on the
// same rising edge and the FIFO advances its head on that edge.
module uart_tx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = UART_CLK_HZ / UART_BAUD,
    parameter int STOP_BITS    = 1,
    parameter int PARITY_EN    = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  tx_en,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    output logic                  fifo_rd,
    output logic                  tx,
    output logic                  busy
);

    localparam int BIT_W = $clog2(DATA_WIDTH) + 1;
    localparam logic [BIT_W-1:0] LAST_DATA = BIT_W'(DATA_WIDTH - 1);
    localparam logic [BIT_W-1:0] LAST_STOP = BIT_W'(STOP_BITS - 1);

    uart_tx_state_t        state, state_n;
    logic [DATA_WIDTH-1:0] shift_q, shift_n;
    logic                  par_q, par_n;
    logic [BIT_W-1:0]      bit_cnt, bit_cnt_n;
    logic                  tx_n;
    logic                  bit_done;

    // Baud timer runs only while a frame is on the line.
    uart_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (state == IDLE),
        .bit_done (bit_done)
    );

    // Pop strobe; gated by rst_n so no word is consumed while held in reset.
    assign fifo_rd = rst_n && (state == IDLE) && tx_en && !fifo_empty;
    assign busy    = (state != IDLE);

    // State, shift register, parity and bit counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            shift_q <= '0;
            par_q   <= 1'b0;
            bit_cnt <= '0;
            tx      <= 1'b1;
        end else begin
            state   <= state_n;
            shift_q <= shift_n;
            par_q   <= par_n;
            bit_cnt <= bit_cnt_n;
            tx      <= tx_n;
        end
    end

    // Next-state logic: frame sequencing, word capture and bit counting.
    always_comb begin
        state_n   = state;
        shift_n   = shift_q;
        par_n     = par_q;
        bit_cnt_n = bit_cnt;
        case (state)
            IDLE: begin
                if (fifo_rd) begin
                    shift_n   = fifo_rd_data;
                    par_n     = ^fifo_rd_data;
                    bit_cnt_n = '0;
                    state_n   = START;
                end
            end
            START: begin
                if (bit_done) state_n = DATA;
            end
            DATA: begin
                if (bit_done) begin
                    shift_n = shift_q >> 1;
                    if (bit_cnt == LAST_DATA) begin
                        bit_cnt_n = '0;
                        state_n   = (PARITY_EN != 0) ? PARITY : STOP;
                    end else begin
                        bit_cnt_n = bit_cnt + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (bit_done) state_n = STOP;
            end
            STOP: begin
                if (bit_done) begin
                    if (bit_cnt == LAST_STOP) begin
                        bit_cnt_n = '0;
                        state_n   = IDLE;
                    end else begin
                        bit_cnt_n = bit_cnt + 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Line level derived from the upcoming state so tx is a clean register
    // that falls on the same edge as the pop.
    always_comb begin
        tx_n = 1'b1;
        case (state_n)
            START:   tx_n = 1'b0;
            DATA:    tx_n = shift_n[0];
            PARITY:  tx_n = par_n;
            default: tx_n = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx with CLKS_PER_BIT=4: one 8N1 instance fed by a
// small FIFO model, and one 8E2 instance fed by a hand-driven FIFO head.
`timescale 1ns/1ps
module tb_uart_tx;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic tx_en = 1'b1;

  // 8N1 instance signals and FIFO model
  logic       fifo_empty;
  logic [7:0] fifo_rd_data;
  logic       fifo_rd, tx, busy;
  logic [7:0] fmem [0:15];
  logic [3:0] fhead = '0;
  logic [3:0] ftail = '0;
  int         fcnt = 0;
  int         rd_count = 0;
  int         rd_empty = 0;
  logic       wr = 1'b0;
  logic [7:0] wr_data = '0;

  // 8E2 instance signals
  logic       p_tx_en = 1'b1;
  logic       p_empty = 1'b1;
  logic [7:0] p_data = 8'h07;
  logic       p_fifo_rd, p_tx, p_busy;

  int total = 0;
  int bad = 0;
  longint last_fall = 0;

  always #5 clk = ~clk;

  assign fifo_empty   = (fcnt == 0);
  assign fifo_rd_data = fmem[fhead];

  // FIFO model: push on wr, pop on fifo_rd; pops against an empty FIFO are tallied.
  always @(posedge clk) begin
    if (wr) begin
      fmem[ftail] <= wr_data;
      ftail <= ftail + 4'd1;
    end
    if (fifo_rd) begin
      rd_count <= rd_count + 1;
      if (fcnt == 0) rd_empty <= rd_empty + 1;
      else fhead <= fhead + 4'd1;
    end
    fcnt <= fcnt + (wr ? 1 : 0) - ((fifo_rd && fcnt != 0) ? 1 : 0);
  end

  uart_tx #(
    .DATA_WIDTH(8), .CLKS_PER_BIT(4), .STOP_BITS(1), .PARITY_EN(0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .tx_en(tx_en), .fifo_empty(fifo_empty),
    .fifo_rd_data(fifo_rd_data), .fifo_rd(fifo_rd), .tx(tx), .busy(busy)
  );

  uart_tx #(
    .DATA_WIDTH(8), .CLKS_PER_BIT(4), .STOP_BITS(2), .PARITY_EN(1)
  ) dut_p (
    .clk(clk), .rst_n(rst_n), .tx_en(p_tx_en), .fifo_empty(p_empty),
    .fifo_rd_data(p_data), .fifo_rd(p_fifo_rd), .tx(p_tx), .busy(p_busy)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] d);
    wr = 1'b1;
    wr_data = d;
    tick();
    wr = 1'b0;
  endtask

  // Wait (bounded) for the pop strobe; a timeout counts as a failed check.
  task automatic wait_pop(input string tag);
    int n = 0;
    while (!fifo_rd && n < 20) begin
      tick();
      n++;
    end
    chk(tag, fifo_rd, 1);
  endtask

  // Called in the pop cycle; checks the full 8N1 frame, 4 cycles per bit.
  // drop_at >= 0 drops tx_en after that many cycles into the frame.
  task automatic check_frame(input string tag, input logic [7:0] d, input int drop_at);
    logic [9:0] frame;
    frame = {1'b1, d, 1'b0};
    chk({tag, "_pop"}, fifo_rd, 1);
    chk({tag, "_pop_tx"}, tx, 1);
    for (int i = 0; i < 40; i++) begin
      tick();
      if (i == 0) last_fall = $time;
      if (i == drop_at) tx_en = 1'b0;
      chk({tag, "_tx"}, tx, frame[i/4]);
      chk({tag, "_busy"}, busy, 1);
      chk({tag, "_rd"}, fifo_rd, 0);
    end
  endtask

  initial begin
    logic [11:0] p_seq;
    longint f0, f1, f2;
    int rc;
    p_seq = 12'b1110_0000_1110;

    // Reset with empty FIFO, tx_en high
    tick();
    chk("rst_tx", tx, 1);
    chk("rst_busy", busy, 0);
    chk("rst_rd", fifo_rd, 0);
    chk("rst_p_tx", p_tx, 1);
    chk("rst_p_busy", p_busy, 0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick();
      chk("idle_tx", tx, 1);
      chk("idle_rd", fifo_rd, 0);
      chk("idle_busy", busy, 0);
    end

    // Single 8N1 frame of 0xA5
    push(8'hA5);
    wait_pop("pop_a5");
    check_frame("a5", 8'hA5, -1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("a5_after_tx", tx, 1);
      chk("a5_after_busy", busy, 0);
      chk("a5_after_rd", fifo_rd, 0);
    end
    chk("a5_rd_count", rd_count, 1);

    // Even parity, two stop bits, word 0x07
    p_empty = 1'b0;
    #1;
    chk("p_pop", p_fifo_rd, 1);
    for (int i = 0; i < 48; i++) begin
      tick();
      if (i == 0) p_empty = 1'b1;
      chk("p_tx", p_tx, p_seq[i/4]);
      chk("p_busy", p_busy, 1);
    end
    tick();
    chk("p_end_tx", p_tx, 1);
    chk("p_end_busy", p_busy, 0);

    // Back-to-back frames from a preloaded FIFO
    tx_en = 1'b0;
    push(8'h01);
    push(8'h02);
    push(8'h03);
    chk("pre_rd_blocked", fifo_rd, 0);
    tx_en = 1'b1;
    #1;
    wait_pop("pop_01");
    check_frame("b01", 8'h01, -1);
    f0 = last_fall;
    tick();
    check_frame("b02", 8'h02, -1);
    f1 = last_fall;
    tick();
    check_frame("b03", 8'h03, -1);
    f2 = last_fall;
    chk("gap_1_2", 32'((f1 - f0) / 10), 41);
    chk("gap_2_3", 32'((f2 - f1) / 10), 41);
    tick();
    chk("b2b_empty", fcnt, 0);
    chk("b2b_busy", busy, 0);
    chk("b2b_rd_count", rd_count, 4);
    chk("b2b_rd_empty", rd_empty, 0);

    // tx_en dropped during data bit 3 of 0x55, 0x66 waiting behind it
    tx_en = 1'b0;
    push(8'h55);
    push(8'h66);
    tx_en = 1'b1;
    #1;
    wait_pop("pop_55");
    check_frame("e55", 8'h55, 16);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("hold_rd", fifo_rd, 0);
      chk("hold_tx", tx, 1);
      chk("hold_busy", busy, 0);
    end
    chk("hold_fcnt", fcnt, 1);
    chk("hold_rd_count", rd_count, 5);
    tx_en = 1'b1;
    #1;
    wait_pop("pop_66");
    check_frame("e66", 8'h66, -1);
    tick();
    chk("e66_empty", fcnt, 0);

    // Reset asserted mid-DATA; next word goes out as a clean frame
    tx_en = 1'b0;
    push(8'h3C);
    push(8'h81);
    tx_en = 1'b1;
    #1;
    wait_pop("pop_3c");
    for (int i = 0; i < 10; i++) tick();
    chk("pre_rst_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_tx", tx, 1);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_rd", fifo_rd, 0);
    rc = rd_count;
    tick();
    chk("mid_rst_rd2", fifo_rd, 0);
    tick();
    chk("mid_rst_nopop", rd_count, rc);
    rst_n = 1'b1;
    #1;
    wait_pop("pop_81");
    check_frame("r81", 8'h81, -1);
    tick();
    chk("r81_empty", fcnt, 0);
    chk("r81_busy", busy, 0);
    chk("r81_rd_count", rd_count, 8);
    chk("final_rd_empty", rd_empty, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
# uart_tx

Serial transmitter that drains a synchronous FIFO and shifts each word out on a single UART line (start bit, LSB-first data, optional even parity, stop bits). It is the reader end of the FIFO: it pops one entry per frame using the FIFO's `rd`/`rd_data`/`empty` handshake, so the processor side only writes the FIFO. It sits between the FIFO and the board TX pin in the MIPS I/O subsystem.

## Interface
- `DATA_WIDTH`, 8: bits per frame; must match the FIFO `DATA_WIDTH`.
- `CLKS_PER_BIT`, 434: clock cycles per bit period (50 MHz / 115200). Must be ≥ 2.
- `STOP_BITS`, 1: number of stop bits, 1 or 2.
- `PARITY_EN`, 0: 1 inserts an even-parity bit after the data bits.

- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `tx_en`  in  1  permits starting new frames. A frame in progress always completes.
- `fifo_empty`  in  1  FIFO empty flag.
- `fifo_rd_data`  in  DATA_WIDTH  FIFO head word; asynchronous read, valid while `fifo_empty`=0.
- `fifo_rd`  out  1  pop strobe to the FIFO `rd`; combinational.
- `tx`  out  1  serial line, idle high; registered.
- `busy`  out  1  high from the cycle after a pop until the final stop-bit cycle ends.

## Operation
- States are IDLE, START, DATA, PARITY, STOP.
  - IDLE → START when `tx_en` && !`fifo_empty`.
  - START → DATA after one bit period.
  - DATA → PARITY (if `PARITY_EN`) or STOP after `DATA_WIDTH` bit periods.
  - PARITY → STOP after one bit period.
  - STOP → IDLE after `STOP_BITS` bit periods.
- Pop: `fifo_rd` = (state==IDLE) && `tx_en` && !`fifo_empty`. On that same edge:
  - `fifo_rd_data` is captured into the shift register.
  - Parity is computed as the XOR of the data bits.
  - State moves to START.
  - `fifo_rd` is never high in any other state, and never high while `fifo_empty`=1.
- `tx` by state:
  - IDLE and STOP: 1.
  - START: 0.
  - DATA: the shift-register LSB; the register shifts right at the end of each bit period.
  - PARITY: the parity bit.
- Counters:
  - Baud counter, width $clog2(CLKS_PER_BIT). Counts 0..CLKS_PER_BIT-1, wraps to 0 at the end of each bit period, and is cleared in IDLE.
  - Bit counter, width $clog2(DATA_WIDTH)+1. Counts data bits, and stop bits while in STOP.
- `tx_en` deassertion only blocks the IDLE → START transition. It does not alter a frame in progress.
- Reset (at any time, including mid-frame):
  - Immediately `tx`=1, `busy`=0, state=IDLE, all counters=0, shift register=0.
  - `fifo_rd`=0 while `rst_n`=0.
  - An aborted word is lost, not re-sent.

## Timing
- Reset values: `tx`=1, `busy`=0, `fifo_rd`=0.
- Latency: `tx` falls on the first clock edge after the pop cycle.
- Line-level frame length: (1 + DATA_WIDTH + PARITY_EN + STOP_BITS) × CLKS_PER_BIT cycles.
- Back-to-back frames: the controller always spends exactly one IDLE cycle (the pop cycle, `tx`=1) between frames.
  - Period = (1 + DATA_WIDTH + PARITY_EN + STOP_BITS) × CLKS_PER_BIT + 1 cycles.
- A FIFO write in the same cycle that the FIFO becomes non-empty is seen as `fifo_empty`=0 on the following cycle. The pop happens in that cycle.
- Simultaneous FIFO write and pop is legal and is handled by the FIFO.

## Structure
- Shared package `uart_pkg` holds:
  - `uart_tx_state_t`, an enum {IDLE, START, DATA, PARITY, STOP}.
  - The default baud constants `UART_CLK_HZ`=50_000_000 and `UART_BAUD`=115_200.
- One optional sub-module, `uart_baud_gen`: the baud counter, with a clear input and a one-cycle `bit_done` pulse output. It is reused by the future receiver.
- Otherwise a single module containing the FSM, shift register and bit counter.

## Test plan
All scenarios use `CLKS_PER_BIT`=4.
- Reset with an empty FIFO, `tx_en`=1 for 50 cycles → `tx`=1, `fifo_rd`=0, `busy`=0 throughout.
- FIFO holds 0xA5 (8N1) → exactly one `fifo_rd` pulse, then `tx` = 0,1,0,1,0,0,1,0,1,1, each held 4 cycles. Total 40 cycles, then idle.
- `PARITY_EN`=1, `STOP_BITS`=2, word 0x07 → bit sequence 0,1,1,1,0,0,0,0,0,1,1,1. Parity = 1 (odd count of ones).
- FIFO preloaded with 0x01, 0x02, 0x03 → three pops, start-bit falling edges 41 cycles apart. `fifo_rd` pulses never overlap `fifo_empty`=1. The FIFO ends empty.
- `tx_en` dropped during bit 3 of 0x55 → the frame completes. No further pop occurs while `tx_en`=0, even though the FIFO holds 0x66. 0x66 is sent after `tx_en` returns high.
- `rst_n` asserted mid-DATA → `tx`=1 and `busy`=0 asynchronously. After release, the next word in the FIFO is sent as a clean frame.
